// File: rtl/op4_dispatcher_if.sv
// STB/BUSY bundle between the dispatcher and its three neighbours:
// upstream word source, the op4 unit, and the downstream sink.
interface op4_dispatcher_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_word;
  logic             in_STB;
  logic             in_BUSY;

  logic [WIDTH-1:0] op_input_a;
  logic [WIDTH-1:0] op_input_b;
  logic [WIDTH-1:0] op_input_c;
  logic [WIDTH-1:0] op_input_d;
  logic             op_input_STB;
  logic             op_BUSY;

  logic [WIDTH-1:0] op_output_result;
  logic             op_output_STB;
  logic             op_output_module_BUSY;

  logic [WIDTH-1:0] out_result;
  logic             out_STB;
  logic             out_BUSY;

  modport master (
    input  in_word,
    input  in_STB,
    output in_BUSY,
    output op_input_a,
    output op_input_b,
    output op_input_c,
    output op_input_d,
    output op_input_STB,
    input  op_BUSY,
    input  op_output_result,
    input  op_output_STB,
    output op_output_module_BUSY,
    output out_result,
    output out_STB,
    input  out_BUSY
  );

  modport slave (
    output in_word,
    output in_STB,
    input  in_BUSY,
    input  op_input_a,
    input  op_input_b,
    input  op_input_c,
    input  op_input_d,
    input  op_input_STB,
    output op_BUSY,
    output op_output_result,
    output op_output_STB,
    input  op_output_module_BUSY,
    input  out_result,
    input  out_STB,
    output out_BUSY
  );
endinterface

// File: rtl/op4_dispatcher.sv
// Collects four operands, issues one op4 request, captures the
// result and forwards it downstream; counts ops and flags timeouts.
module op4_dispatcher #(
  parameter int          WIDTH          = 32,
  parameter int          CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  op4_dispatcher_if.master     bus,
  output logic [CNT_W-1:0]     ops_done,
  output logic                 err_timeout
);

  localparam int TW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LIM =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT,
    ISSUE,
    WAIT_RES,
    DELIVER
  } state_t;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] opnd_q [4];
  logic             in_busy_q;
  logic             op_stb_q;
  logic             mbusy_q;
  logic             out_stb_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] done_q;
  logic [CNT_W-1:0] done_d;
  logic             err_q;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;

  logic in_xfer;
  logic op_xfer;
  logic res_xfer;
  logic out_xfer;
  logic to_hit;

  assign in_xfer  = bus.in_STB && !in_busy_q;
  assign op_xfer  = op_stb_q && !bus.op_BUSY;
  assign res_xfer = bus.op_output_STB && !mbusy_q;
  assign out_xfer = out_stb_q && !bus.out_BUSY;

  assign done_d  = done_q + CNT_W'(1);
  assign timer_d = (&timer_q) ? timer_q
                              : timer_q + TW'(1);
  assign to_hit  = TO_EN && (32'(timer_q) >= TO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      idx_q     <= 2'd0;
      in_busy_q <= 1'b0;
      op_stb_q  <= 1'b0;
      mbusy_q   <= 1'b1;
      out_stb_q <= 1'b0;
      res_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        opnd_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_xfer) begin
            opnd_q[idx_q] <= bus.in_word;
            if (idx_q == 2'd3) begin
              in_busy_q <= 1'b1;
              idx_q     <= 2'd0;
              op_stb_q  <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ISSUE: begin
          if (op_xfer) begin
            op_stb_q <= 1'b0;
            mbusy_q  <= 1'b0;
            timer_q  <= '0;
            state_q  <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_xfer) begin
            res_q     <= bus.op_output_result;
            mbusy_q   <= 1'b1;
            out_stb_q <= 1'b1;
            state_q   <= DELIVER;
          end else begin
            timer_q <= timer_d;
            // a late result is still taken; the flag only records it
            if (to_hit) begin
              err_q <= 1'b1;
            end
          end
        end
        DELIVER: begin
          if (out_xfer) begin
            out_stb_q <= 1'b0;
            done_q    <= done_d;
            in_busy_q <= 1'b0;
            state_q   <= COLLECT;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_BUSY               = in_busy_q;
  assign bus.op_input_a            = opnd_q[0];
  assign bus.op_input_b            = opnd_q[1];
  assign bus.op_input_c            = opnd_q[2];
  assign bus.op_input_d            = opnd_q[3];
  assign bus.op_input_STB          = op_stb_q;
  assign bus.op_output_module_BUSY = mbusy_q;
  assign bus.out_result            = res_q;
  assign bus.out_STB               = out_stb_q;
  assign ops_done                  = done_q;
  assign err_timeout               = err_q;

endmodule

// File: tb/tb_op4_dispatcher.sv
// Directed bench for op4_dispatcher: table of transactions plus
// hand-written timeout and mid-operation reset sequences.
module tb_op4_dispatcher;

  localparam int W  = 32;
  localparam int CW = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op4_dispatcher_if #(.WIDTH(W)) bus();
  logic [CW-1:0] ops_done;
  logic          err_timeout;

  op4_dispatcher #(
    .WIDTH(W),
    .CNT_W(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ops_done(ops_done),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [31:0] a, b, c, d, res;
    int          opb, dly, ob;
    logic [1:0]  cnt;
    logic        err;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   xfers = 0;
  int   exp_xfers = 0;
  logic err_m = 1'b0;

  always @(posedge clk)
    if (rst && bus.op_input_STB && !bus.op_BUSY)
      xfers <= xfers + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] a, b, c, d, res,
    input int opb, dly, ob,
    input logic [1:0] cnt,
    input logic err);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.d = d;
    v.res = res; v.opb = opb; v.dly = dly;
    v.ob = ob; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk_ops(input vec_t v, input string nm);
    check({nm, "_a"}, bus.op_input_a, v.a);
    check({nm, "_b"}, bus.op_input_b, v.b);
    check({nm, "_c"}, bus.op_input_c, v.c);
    check({nm, "_d"}, bus.op_input_d, v.d);
  endtask

  task automatic feed(input vec_t v);
    logic [31:0] w [4];
    w[0] = v.a; w[1] = v.b; w[2] = v.c; w[3] = v.d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("in_busy_collect", 32'(bus.in_BUSY), 0);
      check("op_stb_collect", 32'(bus.op_input_STB), 0);
      bus.in_word = w[i];
      bus.in_STB  = 1'b1;
    end
    @(negedge clk);
    bus.in_STB  = 1'b0;
    bus.op_BUSY = (v.opb > 0);
    check("op_stb_rise", 32'(bus.op_input_STB), 1);
    check("in_busy_issue", 32'(bus.in_BUSY), 1);
    check("mbusy_issue", 32'(bus.op_output_module_BUSY), 1);
    chk_ops(v, "opnd");
  endtask

  task automatic issue(input vec_t v);
    for (int k = 0; k < v.opb; k++) begin
      @(negedge clk);
      check("op_stb_hold", 32'(bus.op_input_STB), 1);
      chk_ops(v, "opnd_hold");
      if (k == v.opb - 1) bus.op_BUSY = 1'b0;
    end
    @(negedge clk);
    exp_xfers++;
    check("op_stb_drop", 32'(bus.op_input_STB), 0);
    check("mbusy_wait", 32'(bus.op_output_module_BUSY), 0);
    check("op_xfer_count", xfers, exp_xfers);
  endtask

  task automatic wait_res(input vec_t v);
    bus.op_output_result = v.res;
    bus.op_output_STB    = (v.dly == 0);
    for (int k = 1; k <= v.dly; k++) begin
      @(negedge clk);
      check("err_wait", 32'(err_timeout),
            32'(err_m || (k >= TO)));
      check("out_stb_wait", 32'(bus.out_STB), 0);
      if (k == v.dly) bus.op_output_STB = 1'b1;
    end
    if (v.dly >= TO) err_m = 1'b1;
    @(negedge clk);
    bus.op_output_STB = 1'b0;
    check("out_stb_rise", 32'(bus.out_STB), 1);
    check("out_result", bus.out_result, v.res);
    check("mbusy_back", 32'(bus.op_output_module_BUSY), 1);
    check("err_after_res", 32'(err_timeout), 32'(v.err));
  endtask

  task automatic deliver(input vec_t v);
    logic [1:0] prev;
    prev = v.cnt - 2'd1;
    bus.out_BUSY = (v.ob > 0);
    for (int k = 0; k < v.ob; k++) begin
      @(negedge clk);
      check("out_stb_hold", 32'(bus.out_STB), 1);
      check("out_res_hold", bus.out_result, v.res);
      check("in_busy_deliver", 32'(bus.in_BUSY), 1);
      check("ops_hold", 32'(ops_done), 32'(prev));
      bus.in_word = 32'hDEAD_0000 + 32'(k);
      bus.in_STB  = (k != v.ob - 1);
      if (k == v.ob - 1) bus.out_BUSY = 1'b0;
    end
    @(negedge clk);
    check("out_stb_drop", 32'(bus.out_STB), 0);
    check("ops_done", 32'(ops_done), 32'(v.cnt));
    check("in_busy_free", 32'(bus.in_BUSY), 0);
    check("err_final", 32'(err_timeout), 32'(v.err));
  endtask

  task automatic run(input vec_t v);
    feed(v);
    issue(v);
    wait_res(v);
    deliver(v);
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_in_busy"}, 32'(bus.in_BUSY), 0);
    check({nm, "_op_stb"}, 32'(bus.op_input_STB), 0);
    check({nm, "_mbusy"}, 32'(bus.op_output_module_BUSY), 1);
    check({nm, "_out_stb"}, 32'(bus.out_STB), 0);
    check({nm, "_a"}, bus.op_input_a, 0);
    check({nm, "_d"}, bus.op_input_d, 0);
    check({nm, "_res"}, bus.out_result, 0);
    check({nm, "_ops"}, 32'(ops_done), 0);
    check({nm, "_err"}, 32'(err_timeout), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    vec_t v;
    tbl[0] = mk(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                32'h4080_0000, 32'h4120_0000, 0, 0, 0, 2'd1, 1'b0);
    tbl[1] = mk(32'hC000_0000, 32'h3F00_0000, 32'h7F80_0000,
                32'h0000_0001, 32'hBF80_0000, 10, 2, 0, 2'd2, 1'b0);
    tbl[2] = mk(32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                32'h4444_4444, 32'hA5A5_5A5A, 0, 1, 5, 2'd3, 1'b0);
    tbl[3] = mk(32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
                32'h7FFF_FFFF, 32'h0BAD_F00D, 3, 3, 2, 2'd0, 1'b0);
    tbl[4] = mk(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C,
                32'h0D0E_0F10, 32'hCAFE_BABE, 1, 7, 1, 2'd1, 1'b0);

    bus.in_word = '0;
    bus.in_STB = 1'b0;
    bus.op_BUSY = 1'b0;
    bus.op_output_result = '0;
    bus.op_output_STB = 1'b0;
    bus.out_BUSY = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run(tbl[i]);

    v = mk(32'h4100_0000, 32'h4110_0000, 32'h4120_0000,
           32'h4130_0000, 32'h1234_5678, 0, 20, 0, 2'd2, 1'b1);
    run(v);
    v = mk(32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC,
           32'h0000_00DD, 32'h8765_4321, 0, 1, 0, 2'd3, 1'b1);
    run(v);

    v = mk(32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
           32'h8888_8888, 32'h0, 0, 0, 0, 2'd0, 1'b0);
    feed(v);
    issue(v);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset("mid_reset");
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = mk(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
           32'h3F80_0000, 32'h4080_0000, 0, 0, 1, 2'd1, 1'b0);
    run(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
